bullet_monitor: RTL and testbench

// - Far end of the bullet handshake. Watches the bullet's bx/by/bd each clock, decides when a flight ends, and returns ready.
// - A flight ends on a hit on the enemy tank or on leaving the playfield. Also keeps the hit score and a win flag.
// - Sits between the bullet FSM and the game/draw control.

---
 rtl/bullet_pkg.sv | 19 +
 rtl/tank_box_cmp.sv | 35 +++
 rtl/bullet_monitor.sv | 155 +++++++++++++++
 tb/tb_bullet_monitor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// Shared bullet definitions: direction codes, coordinate widths, monitor states.
package bullet_pkg;

  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;

  localparam logic [2:0] BD_UP    = 3'b100;
  localparam logic [2:0] BD_DOWN  = 3'b101;
  localparam logic [2:0] BD_LEFT  = 3'b110;
  localparam logic [2:0] BD_RIGHT = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    FLIGHT  = 2'd2,
    RELEASE = 2'd3
  } mon_state_t;

endpackage

// File: rtl/tank_box_cmp.sv
// Combinational point-in-box test against a TANK_SIZE square anchored at its top-left corner.
// Bounds are widened by one bit so the far edge cannot wrap near the field limit.
module tank_box_cmp
  import bullet_pkg::*;
#(
  parameter int unsigned TANK_SIZE = 4
) (
  input  logic [X_W-1:0] i_px,
  input  logic [Y_W-1:0] i_py,
  input  logic [X_W-1:0] i_ox,
  input  logic [Y_W-1:0] i_oy,
  output logic           o_in_box_c
);

  localparam int unsigned XB_W = X_W + 1;
  localparam int unsigned YB_W = Y_W + 1;

  logic [XB_W-1:0] w_px;
  logic [XB_W-1:0] w_x_lo;
  logic [XB_W-1:0] w_x_hi;
  logic [YB_W-1:0] w_py;
  logic [YB_W-1:0] w_y_lo;
  logic [YB_W-1:0] w_y_hi;

  assign w_px   = {1'b0, i_px};
  assign w_x_lo = {1'b0, i_ox};
  assign w_x_hi = w_x_lo + XB_W'(TANK_SIZE - 1);
  assign w_py   = {1'b0, i_py};
  assign w_y_lo = {1'b0, i_oy};
  assign w_y_hi = w_y_lo + YB_W'(TANK_SIZE - 1);

  assign o_in_box_c = (w_px >= w_x_lo) && (w_px <= w_x_hi) &&
                      (w_py >= w_y_lo) && (w_py <= w_y_hi);

endmodule

// File: rtl/bullet_monitor.sv
// Far end of the bullet handshake: ends flights on enemy hit or out-of-bounds,
// returns ready, keeps a saturating hit score and a win flag.
// Optional flight timeout enabled by defining BULLET_MON_TIMEOUT_EN.
module bullet_monitor
  import bullet_pkg::*;
#(
  parameter int unsigned X_MAX     = 159,
  parameter int unsigned Y_MAX     = 119,
  parameter int unsigned TANK_SIZE = 4,
  parameter int unsigned SCORE_W   = 4,
  parameter int unsigned WIN_SCORE = 3
`ifdef BULLET_MON_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     bx,
  input  logic [Y_W-1:0]     by,
  input  logic [2:0]         bd,
  input  logic [X_W-1:0]     ex,
  input  logic [Y_W-1:0]     ey,
  output logic               ready,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic               win
);

  mon_state_t         r_state;
  logic               r_ready;
  logic               r_hit;
  logic               r_miss;
  logic [SCORE_W-1:0] r_score;
  logic               r_win;

  mon_state_t         w_nx_state;
  logic               w_nx_ready;
  logic               w_nx_hit;
  logic               w_nx_miss;
  logic [SCORE_W-1:0] w_nx_score;
  logic               w_nx_win;

  logic               w_in_box;
  logic               w_oob;
  logic               w_timeout;
  logic               w_unused_dir;

  // Direction bits are carried for the bullet FSM; only the in-flight flag matters here.
  assign w_unused_dir = ^bd[1:0];

  tank_box_cmp #(
    .TANK_SIZE (TANK_SIZE)
  ) u_enemy_box (
    .i_px       (bx),
    .i_py       (by),
    .i_ox       (ex),
    .i_oy       (ey),
    .o_in_box_c (w_in_box)
  );

  // Out of the field; also catches the 0->max underflow wrap of the bullet coordinates.
  assign w_oob = (bx > X_W'(X_MAX)) || (by > Y_W'(Y_MAX));

`ifdef BULLET_MON_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_flight_cnt;

  // Flight-cycle counter: held at zero outside FLIGHT, so it restarts on every entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_flight_cnt <= '0;
    end else if (r_state != FLIGHT) begin
      r_flight_cnt <= '0;
    end else begin
      r_flight_cnt <= r_flight_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == FLIGHT) && (r_flight_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Next state and next registered outputs; hit beats out-of-bounds beats timeout.
  always_comb begin
    w_nx_state = r_state;
    w_nx_ready = r_ready;
    w_nx_hit   = 1'b0;
    w_nx_miss  = 1'b0;
    w_nx_score = r_score;
    unique case (r_state)
      IDLE: begin
        if (start) w_nx_state = ARMED;
      end
      ARMED: begin
        if (bd[2]) w_nx_state = FLIGHT;
      end
      FLIGHT: begin
        if (w_in_box) begin
          w_nx_state = RELEASE;
          w_nx_ready = 1'b1;
          w_nx_hit   = 1'b1;
          if (r_score < SCORE_W'(WIN_SCORE)) w_nx_score = r_score + SCORE_W'(1);
        end else if (w_oob || w_timeout) begin
          w_nx_state = RELEASE;
          w_nx_ready = 1'b1;
          w_nx_miss  = 1'b1;
        end else if (!bd[2]) begin
          w_nx_state = ARMED;
        end
      end
      RELEASE: begin
        if (!bd[2]) begin
          w_nx_state = ARMED;
          w_nx_ready = 1'b0;
        end
      end
      default: begin
        w_nx_state = IDLE;
        w_nx_ready = 1'b0;
      end
    endcase
    w_nx_win = (w_nx_score == SCORE_W'(WIN_SCORE));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
      r_score <= '0;
      r_win   <= 1'b0;
    end else begin
      r_state <= w_nx_state;
      r_ready <= w_nx_ready;
      r_hit   <= w_nx_hit;
      r_miss  <= w_nx_miss;
      r_score <= w_nx_score;
      r_win   <= w_nx_win;
    end
  end

  assign ready = r_ready;
  assign hit   = r_hit;
  assign miss  = r_miss;
  assign score = r_score;
  assign win   = r_win;

endmodule

// File: tb/tb_bullet_monitor.sv
// Bench for bullet_monitor: table of per-cycle vectors with a scoreboard queue,
// plus hand-written reset-in-RELEASE and long-flight sequences.
module tb_bullet_monitor;
  import bullet_pkg::*;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [7:0] bx;
  logic [6:0] by;
  logic [2:0] bd;
  logic [7:0] ex;
  logic [6:0] ey;
  logic       ready;
  logic       hit;
  logic       miss;
  logic [3:0] score;
  logic       win;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic       ready;
    logic       hit;
    logic       miss;
    logic [3:0] score;
    logic       win;
  } out_t;

  typedef struct {
    logic       start;
    logic [7:0] bx;
    logic [6:0] by;
    logic [2:0] bd;
    out_t       exp;
  } vec_t;

  out_t sb_q[$];
  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bullet_monitor dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .bx     (bx),
    .by     (by),
    .bd     (bd),
    .ex     (ex),
    .ey     (ey),
    .ready  (ready),
    .hit    (hit),
    .miss   (miss),
    .score  (score),
    .win    (win)
  );

  function automatic vec_t mk(input logic st, input int x, input int y, input logic [2:0] d,
                              input logic r, input logic h, input logic m, input int s, input logic w);
    vec_t v;
    v.start     = st;
    v.bx        = 8'(x);
    v.by        = 7'(y);
    v.bd        = d;
    v.exp.ready = r;
    v.exp.hit   = h;
    v.exp.miss  = m;
    v.exp.score = 4'(s);
    v.exp.win   = w;
    return v;
  endfunction

  task automatic compare(input string name);
    out_t e;
    out_t a;
    a = {ready, hit, miss, score, win};
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got ready=%0b hit=%0b miss=%0b score=%0d win=%0b, expected ready=%0b hit=%0b miss=%0b score=%0d win=%0b",
                 name, a.ready, a.hit, a.miss, a.score, a.win,
                 e.ready, e.hit, e.miss, e.score, e.win);
      end
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one vector just after an edge, then check outputs just after the next edge.
  task automatic apply(input vec_t v, input string name);
    start = v.start;
    bx    = v.bx;
    by    = v.by;
    bd    = v.bd;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    compare(name);
  endtask

  initial begin
    int cyc;
    int got_ready;
    int got_miss;

    resetn = 1'b0;
    start  = 1'b0;
    bx     = '0;
    by     = '0;
    bd     = 3'b000;
    ex     = 8'd50;
    ey     = 7'd30;

    // Box spans x 50..53, y 30..33
    tbl.push_back(mk(1,  0,   0, 3'b000, 0,0,0,0,0)); //  0 IDLE->ARMED
    tbl.push_back(mk(0, 20,  20, BD_UP,  0,0,0,0,0)); //  1 ARMED->FLIGHT
    tbl.push_back(mk(0, 20,  20, BD_UP,  0,0,0,0,0)); //  2 flying, no end
    tbl.push_back(mk(0, 51,  33, BD_UP,  1,1,0,1,0)); //  3 hit
    tbl.push_back(mk(0, 51,  33, BD_UP,  1,0,0,1,0)); //  4 ready held, pulse gone
    tbl.push_back(mk(0, 10,  10, BD_UP,  1,0,0,1,0)); //  5 moves ignored in RELEASE
    tbl.push_back(mk(0, 10,  10, 3'b000, 0,0,0,1,0)); //  6 bd drop releases ready
    tbl.push_back(mk(0, 54,  31, BD_UP,  0,0,0,1,0)); //  7 ARMED->FLIGHT
    tbl.push_back(mk(0, 54,  31, BD_UP,  0,0,0,1,0)); //  8 right of box
    tbl.push_back(mk(0, 49,  31, BD_UP,  0,0,0,1,0)); //  9 left of box
    tbl.push_back(mk(0, 53,  31, BD_UP,  1,1,0,2,0)); // 10 right edge hit
    tbl.push_back(mk(0, 53,  31, 3'b000, 0,0,0,2,0)); // 11
    tbl.push_back(mk(0, 20,  20, BD_DOWN,0,0,0,2,0)); // 12
    tbl.push_back(mk(0, 20, 127, BD_UP,  1,0,1,2,0)); // 13 y underflow wrap
    tbl.push_back(mk(0, 20, 127, 3'b000, 0,0,0,2,0)); // 14
    tbl.push_back(mk(0, 20,  20, BD_LEFT,0,0,0,2,0)); // 15
    tbl.push_back(mk(0,255,  20, BD_LEFT,1,0,1,2,0)); // 16 x underflow wrap
    tbl.push_back(mk(0,255,  20, 3'b000, 0,0,0,2,0)); // 17
    tbl.push_back(mk(0, 20,  20, BD_UP,  0,0,0,2,0)); // 18
    tbl.push_back(mk(0, 50,  30, BD_UP,  1,1,0,3,1)); // 19 third hit -> win
    tbl.push_back(mk(0, 50,  30, 3'b000, 0,0,0,3,1)); // 20
    tbl.push_back(mk(0, 20,  20, BD_UP,  0,0,0,3,1)); // 21
    tbl.push_back(mk(0, 53,  33, BD_UP,  1,1,0,3,1)); // 22 saturated hit
    tbl.push_back(mk(0, 53,  33, 3'b000, 0,0,0,3,1)); // 23
    tbl.push_back(mk(0, 20,  20, BD_UP,  0,0,0,3,1)); // 24
    tbl.push_back(mk(0, 20,  20, BD_UP,  0,0,0,3,1)); // 25
    tbl.push_back(mk(0, 20,  20, 3'b000, 0,0,0,3,1)); // 26 abort, no ready
    tbl.push_back(mk(0, 20,  20, 3'b000, 0,0,0,3,1)); // 27
    tbl.push_back(mk(1, 20,  20, 3'b000, 0,0,0,3,1)); // 28 start ignored
    tbl.push_back(mk(0, 20,  20, BD_RIGHT,0,0,0,3,1));// 29
    tbl.push_back(mk(0,160,   0, BD_RIGHT,1,0,1,3,1));// 30 first column past X_MAX
    tbl.push_back(mk(0,160,   0, 3'b000, 0,0,0,3,1)); // 31
    tbl.push_back(mk(0, 20,  20, BD_DOWN,0,0,0,3,1)); // 32
    tbl.push_back(mk(0,159, 119, BD_DOWN,0,0,0,3,1)); // 33 last valid corner
    tbl.push_back(mk(0,159, 120, BD_DOWN,1,0,1,3,1)); // 34 first row past Y_MAX
    tbl.push_back(mk(0,159, 120, 3'b000, 0,0,0,3,1)); // 35

    #12;
    sb_q.push_back('0);
    compare("reset_state");
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while ready is high clears everything without a clock edge.
    apply(mk(0, 20, 20, BD_UP, 0,0,0,3,1), "rel_arm");
    apply(mk(0, 51, 33, BD_UP, 1,1,0,3,1), "rel_hit");
    #2;
    resetn = 1'b0;
    #1;
    sb_q.push_back('0);
    compare("reset_mid_release");
    @(negedge clk);
    resetn = 1'b1;

    // Long flight parked inside the field away from the enemy.
    @(posedge clk);
    #1;
    apply(mk(1, 10, 10, 3'b000, 0,0,0,0,0), "to_armed");
    apply(mk(0, 10, 10, BD_UP,  0,0,0,0,0), "to_flight");
    got_ready = 0;
    got_miss  = 0;
    cyc       = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        got_ready = 1;
        got_miss  = int'(miss);
        cyc       = k;
        break;
      end
    end
`ifdef BULLET_MON_TIMEOUT_EN
    check_val("timeout_ready", got_ready, 1);
    check_val("timeout_cycle", cyc, 64);
    check_val("timeout_miss", got_miss, 1);
    check_val("timeout_score", int'(score), 0);
`else
    check_val("no_timeout_ready", got_ready, 0);
    check_val("no_timeout_score", int'(score), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
